// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//
// Sequences one CPU "session": stream a program into instruction memory,
// enable the CPU for a fixed number of clocks, then read a block of data
// memory back out over a valid/ready stream.  Phases with a zero length are
// skipped; a session with every length zero goes straight to DONE.
//
// Ports
//   clk, arst_n            clock, asynchronous active-low reset
//   start, abort           session request / synchronous return to IDLE
//   imem_len[9:0]          program words to load (clamped to IMEM_DEPTH)
//   run_cycles[15:0]       clocks of cpu_enable
//   dump_len[10:0]         data words to read back (clamped to DMEM_DEPTH)
//   s_valid/s_data/s_ready instruction load stream (sink)
//   m_valid/m_data/m_ready data dump stream (source)
//   addr_ext, wen_ext, ren_ext, wdata_ext
//                          instruction-memory external port (write only)
//   addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, rdata_ext_2
//                          data-memory external port (read only, 1-cycle
//                          read latency)
//   cpu_enable, busy, done CPU enable, not-IDLE flag, completion pulse
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  imem_len,
  input  logic [15:0] run_cycles,
  input  logic [10:0] dump_len,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [31:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [31:0] wdata_ext_2,
  input  logic [31:0] rdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done
);

  // Clamp limits expressed in the width of the matching length input; a
  // depth larger than the input can express simply never clamps.
  localparam logic [9:0]  IMEM_CAP = (IMEM_DEPTH > 1023) ? 10'd1023 : 10'(IMEM_DEPTH);
  localparam logic [10:0] DMEM_CAP = (DMEM_DEPTH > 2047) ? 11'd2047 : 11'(DMEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RUN      = 3'd2,
    DUMP_RD  = 3'd3,
    DUMP_OUT = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  load_len_q, load_len_d;
  logic [15:0] run_len_q, run_len_d;
  logic [10:0] dump_len_q, dump_len_d;
  logic [9:0]  load_cnt_q, load_cnt_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [10:0] dump_cnt_q, dump_cnt_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;

  logic [9:0]  imem_len_clamped;
  logic [10:0] dump_len_clamped;
  logic        load_xfer;

  // First phase with work left, in session order.
  function automatic state_t first_phase(input logic [9:0]  l,
                                         input logic [15:0] r,
                                         input logic [10:0] d);
    state_t s;
    if (l != 10'd0)      s = LOAD;
    else if (r != 16'd0) s = RUN;
    else if (d != 11'd0) s = DUMP_RD;
    else                 s = DONE;
    return s;
  endfunction

  assign imem_len_clamped = (imem_len > IMEM_CAP) ? IMEM_CAP : imem_len;
  assign dump_len_clamped = (dump_len > DMEM_CAP) ? DMEM_CAP : dump_len;

  // s_ready is high for the whole of LOAD, so a transfer is just s_valid.
  assign load_xfer = (state_q == LOAD) && s_valid;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      load_len_q <= '0;
      run_len_q  <= '0;
      dump_len_q <= '0;
      load_cnt_q <= '0;
      run_cnt_q  <= '0;
      dump_cnt_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      load_len_q <= load_len_d;
      run_len_q  <= run_len_d;
      dump_len_q <= dump_len_d;
      load_cnt_q <= load_cnt_d;
      run_cnt_q  <= run_cnt_d;
      dump_cnt_q <= dump_cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_len_d = load_len_q;
    run_len_d  = run_len_q;
    dump_len_d = dump_len_q;
    load_cnt_d = load_cnt_q;
    run_cnt_d  = run_cnt_q;
    dump_cnt_d = dump_cnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;

    if (abort) begin
      // Wins over start and over any handshake in the same cycle; a word
      // written to IMEM this cycle still lands but is not counted.
      state_d    = IDLE;
      load_cnt_d = '0;
      run_cnt_d  = '0;
      dump_cnt_d = '0;
      m_valid_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            load_len_d = imem_len_clamped;
            run_len_d  = run_cycles;
            dump_len_d = dump_len_clamped;
            load_cnt_d = '0;
            run_cnt_d  = '0;
            dump_cnt_d = '0;
            state_d    = first_phase(imem_len_clamped, run_cycles, dump_len_clamped);
          end
        end
        LOAD: begin
          if (load_xfer) begin
            if (load_cnt_q + 10'd1 == load_len_q) begin
              load_cnt_d = '0;
              state_d    = first_phase(10'd0, run_len_q, dump_len_q);
            end else begin
              load_cnt_d = load_cnt_q + 10'd1;
            end
          end
        end
        RUN: begin
          if (run_cnt_q == run_len_q - 16'd1) begin
            run_cnt_d = '0;
            state_d   = first_phase(10'd0, 16'd0, dump_len_q);
          end else begin
            run_cnt_d = run_cnt_q + 16'd1;
          end
        end
        DUMP_RD: begin
          state_d = DUMP_OUT;
        end
        DUMP_OUT: begin
          // Read data for the address issued in DUMP_RD is on rdata_ext_2
          // during the first DUMP_OUT cycle; capture it then and present it
          // until the consumer takes it.
          if (!m_valid_q) begin
            m_data_d  = rdata_ext_2;
            m_valid_d = 1'b1;
          end else if (m_ready) begin
            m_valid_d = 1'b0;
            if (dump_cnt_q + 11'd1 == dump_len_q) begin
              dump_cnt_d = '0;
              state_d    = DONE;
            end else begin
              dump_cnt_d = dump_cnt_q + 11'd1;
              state_d    = DUMP_RD;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Instruction-memory port: active only on load handshakes.
  assign s_ready   = (state_q == LOAD);
  assign wen_ext   = load_xfer;
  assign addr_ext  = load_xfer ? {20'd0, load_cnt_q, 2'b00} : 32'd0;
  assign wdata_ext = load_xfer ? s_data : 32'd0;
  assign ren_ext   = 1'b0;

  // Data-memory port: read only, one request per DUMP_RD cycle.
  assign ren_ext_2   = (state_q == DUMP_RD);
  assign addr_ext_2  = ren_ext_2 ? {19'd0, dump_cnt_q, 2'b00} : 32'd0;
  assign wen_ext_2   = 1'b0;
  assign wdata_ext_2 = 32'd0;

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign cpu_enable = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule
